// File: rtl/my_risc_pkg.sv
// Shared definitions for the fetch front end: word width, the canonical NOP
// and the buffered instruction/PC entry type.
package my_risc_pkg;

  localparam int XLEN = 32;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPCODE_OP_IMM};
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instruction/PC pairs with a flush that
// empties it in one cycle.
module fetch_fifo import my_risc_pkg::*; #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

  // The fetch credit scheme must make a push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (rst) do_push |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order requests to instruction
// memory, buffered responses, and redirect with discard of stale responses.
module fetch_unit #(
  parameter logic [my_risc_pkg::XLEN-1:0] RESET_PC  = my_risc_pkg::RESET_PC_DEFAULT,
  parameter int                           BUF_DEPTH = 2,
  parameter logic [my_risc_pkg::XLEN-1:0] NOP_INSTR = my_risc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  import my_risc_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] last_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   occupancy;
  logic            req_fire;
  logic            keep_rsp;
  logic            pop;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // A request may only go out if its response is guaranteed a buffer slot.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign keep_rsp       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready;

  assign outstanding_next = outstanding + {{(CW-1){1'b0}}, req_fire}
                                        - {{(CW-1){1'b0}}, imem_rsp_valid};

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = rsp_pc;
    push_entry.instr = imem_rsp_data;
  end

  // On redirect every response still in flight belongs to the old stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= word_align(RESET_PC);
      rsp_pc      <= word_align(RESET_PC);
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        rsp_pc   <= word_align(redirect_pc);
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (keep_rsp) rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_pc <= word_align(RESET_PC);
    else if (instr_valid) last_pc <= head.pc;
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep_rsp),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (occupancy),
    .empty     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = instr_valid ? head.pc : last_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a pipelined memory model answers each
// request with addr^32'h13, and monitors check fetched words and request addresses.
module tb_fetch_unit;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  // Memory model: response latency of memSel+1 cycles, in order.
  logic [3:0]  mem_v;
  logic [31:0] mem_d [4];
  logic [1:0]  memSel;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) mem_v <= '0;
    else     mem_v <= {mem_v[2:0], imem_req_valid && imem_req_ready};
    mem_d[0] <= imem_req_addr ^ 32'h13;
    for (int i = 1; i < 4; i++) mem_d[i] <= mem_d[i-1];
  end

  assign imem_rsp_valid = mem_v[memSel];
  assign imem_rsp_data  = mem_d[memSel];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    @(posedge clk); #1;
  endtask

  task automatic resetDut(input logic [1:0] sel);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    memSel = sel;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_instr_pc", instr_pc, RESET_PC);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic consume(input int n);
    int got = 0;
    int cyc = 0;
    instr_ready = 1'b1;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      if (instr_valid) got++;
      @(posedge clk); #1;
      cyc++;
    end
    instr_ready = 1'b0;
    checkOutput("consume_count", got, n);
  endtask

  // Scoreboard monitor for delivered instructions and issued request addresses.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && instr_valid && instr_ready) begin
      if (exp_pc_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_instr: got pc %h with no expected entry", instr_pc);
      end else begin
        e = exp_pc_q.pop_front();
        checkOutput("instr_pc", instr_pc, e);
        checkOutput("instr", instr, e ^ 32'h13);
      end
    end
    if (!rst && imem_req_valid && imem_req_ready && exp_addr_q.size() > 0) begin
      e = exp_addr_q.pop_front();
      checkOutput("req_addr", imem_req_addr, e);
    end
  end

  initial begin
    int fires;
    int firstValid;
    int stableBad;
    logic [31:0] snapInstr;
    logic [31:0] snapPc;

    imem_req_ready = 1'b1;

    // Back-pressure from decode: two requests fill the buffer, output holds.
    resetDut(2'd0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    fires = 0; firstValid = 0; stableBad = 0;
    snapInstr = '0; snapPc = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
      if (instr_valid && firstValid == 0) begin
        firstValid = k;
        snapInstr = instr;
        snapPc = instr_pc;
      end else if (firstValid != 0 && (instr !== snapInstr || instr_pc !== snapPc || !instr_valid)) begin
        stableBad++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("first_valid_cycle", firstValid, 3);
    checkOutput("requests_when_stalled", fires, 2);
    checkOutput("req_valid_stalled", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("held_stable", stableBad, 0);
    checkOutput("held_pc", snapPc, 32'h0);
    @(posedge clk); #1;
    exp_addr_q.push_back(32'h8);
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    exp_pc_q.push_back(32'h8);
    consume(3);

    // Redirect with two requests in flight on a 3-cycle memory.
    resetDut(2'd2);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h1000);
    exp_addr_q.push_back(32'h1004);
    exp_addr_q.push_back(32'h1008);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_1002, 1'b0);
    redirect_valid = 1'b0;
    @(negedge clk);
    checkOutput("req_blocked_while_dropping", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    exp_pc_q.push_back(32'h1000);
    exp_pc_q.push_back(32'h1004);
    exp_pc_q.push_back(32'h1008);
    consume(3);

    // Redirect coinciding with a response and a pop.
    resetDut(2'd0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    exp_pc_q.push_back(32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1'b1;
    @(negedge clk);
    checkOutput("pre_rsp_valid", {31'd0, imem_rsp_valid}, 32'd1);
    checkOutput("pre_instr_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    checkOutput("flush_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("flush_instr_nop", instr, NOP);
    checkOutput("flush_instr_pc_hold", instr_pc, 32'h0);
    checkOutput("flush_req_valid", {31'd0, imem_req_valid}, 32'd1);
    @(posedge clk); #1;
    exp_pc_q.push_back(32'h200);
    exp_pc_q.push_back(32'h204);
    consume(2);

    // Redirect near the top of the address space wraps to zero.
    resetDut(2'd0);
    exp_addr_q.push_back(32'hFFFF_FFF8);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0000_0000);
    exp_pc_q.push_back(32'hFFFF_FFF8);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'h0000_0000);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
    redirect_valid = 1'b0;
    consume(3);

    // Reset while a word is buffered and another is in flight.
    resetDut(2'd0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("post_rst_instr", instr, NOP);
    checkOutput("post_rst_instr_pc", instr_pc, RESET_PC);
    checkOutput("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    @(posedge clk); #1;
    exp_pc_q.push_back(32'h0);
    exp_pc_q.push_back(32'h4);
    consume(2);

    checkOutput("sb_instr_drained", exp_pc_q.size(), 0);
    checkOutput("sb_addr_drained", exp_addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
